// File: rtl/reveal_flood_controller.sv
// reveal_flood_controller: sequences the board RAM port for one cell reveal.
// Counts neighbour mines, writes the count, and flood-fills zero regions.
module reveal_flood_controller #(
   parameter int ROWS          = 5,
   parameter int COLS          = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 10,
   parameter int BASE_ADDR     = 0,
   parameter int HIDDEN_SAFE   = 9,
   parameter int HIDDEN_MINE   = 10,
   localparam int CELLS = ROWS * COLS,
   localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1,
   localparam int CW    = $clog2(CELLS + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [IW-1:0]            start_id,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic                     mem_wEn,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   output logic                     busy,
   output logic                     done,
   output logic                     hit_mine,
   output logic [CW-1:0]            revealed_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_POP,
      S_SCAN,
      S_WRITE,
      S_PUSH,
      S_DONE
   } state_e;

   state_e state_q, state_d;

   logic [IW-1:0]            cur_q, cur_d;
   logic [3:0]               k_q, k_d;
   logic                     pend_q, pend_d;
   logic [2:0]               pk_q, pk_d;
   logic [3:0]               cnt_q, cnt_d;
   logic [7:0]               mask_q, mask_d, mask_nxt;
   logic [CELLS-1:0]         vis_q, vis_d;
   logic [IW-1:0]            wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]            fcnt_q, fcnt_d;
   logic                     hit_q, hit_d;
   logic [CW-1:0]            rev_q, rev_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic                     wen_q, wen_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;

   logic [IW-1:0] fifo_q [CELLS];
   logic          push;
   logic [IW-1:0] push_id;

   int            cur_r, cur_c;
   logic          nb_k_ok;
   logic [IW-1:0] nb_k, nb_p, nb_l;
   logic [2:0]    lo;
   logic          rd_mine, rd_safe, start_ok;

   // Neighbour order k=0..7 is NW, N, NE, W, E, SW, S, SE.
   function automatic int off_r(input logic [2:0] k);
      return (k < 3'd3) ? -1 : ((k > 3'd4) ? 1 : 0);
   endfunction

   function automatic int off_c(input logic [2:0] k);
      int o;
      case (k)
         3'd0, 3'd3, 3'd5: o = -1;
         3'd1, 3'd6:       o = 0;
         default:          o = 1;
      endcase
      return o;
   endfunction

   function automatic logic nb_in(input int r, input int c,
                                  input logic [2:0] k);
      int nr, nc;
      nr = r + off_r(k);
      nc = c + off_c(k);
      return (nr >= 0) && (nr < ROWS) && (nc >= 0) && (nc < COLS);
   endfunction

   function automatic logic [IW-1:0] nb_id(input int r, input int c,
                                           input logic [2:0] k);
      return IW'((r + off_r(k)) * COLS + c + off_c(k));
   endfunction

   function automatic logic [ADDRESS_WIDTH-1:0] cell_addr(
      input logic [IW-1:0] id);
      return ADDRESS_WIDTH'(BASE_ADDR + int'(id));
   endfunction

   function automatic logic [IW-1:0] inc(input logic [IW-1:0] p);
      return (int'(p) == CELLS - 1) ? '0 : p + 1'b1;
   endfunction

   always_comb begin : decode
      cur_r    = int'(cur_q) / COLS;
      cur_c    = int'(cur_q) % COLS;
      nb_k_ok  = nb_in(cur_r, cur_c, k_q[2:0]);
      nb_k     = nb_id(cur_r, cur_c, k_q[2:0]);
      nb_p     = nb_id(cur_r, cur_c, pk_q);
      lo       = 3'd0;
      for (int j = 7; j >= 0; j--) begin
         if (mask_q[j]) lo = 3'(j);
      end
      nb_l     = nb_id(cur_r, cur_c, lo);
      mask_nxt = mask_q & (mask_q - 8'd1);
      rd_mine  = (mem_rdata == DATA_WIDTH'(HIDDEN_MINE));
      rd_safe  = (mem_rdata == DATA_WIDTH'(HIDDEN_SAFE));
      start_ok = (int'(start_id) < CELLS);
   end

   always_ff @(posedge clk or negedge rst_n) begin : state_reg
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = start_ok ? S_CHECK : S_DONE;
         S_CHECK: state_d = rd_safe ? S_POP : S_DONE;
         S_POP:   state_d = (fcnt_q == '0) ? S_DONE : S_SCAN;
         S_SCAN:  if (k_q == 4'd8) state_d = S_WRITE;
         S_WRITE: begin
            if (cnt_q == 4'd0 && mask_q != 8'd0) state_d = S_PUSH;
            else                                 state_d = S_POP;
         end
         S_PUSH:  if (mask_nxt == 8'd0) state_d = S_POP;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin : outputs
      busy = (state_q != S_IDLE) && (state_q != S_DONE);
      done = (state_q == S_DONE);
   end

   always_comb begin : dp_next
      cur_d   = cur_q;
      k_d     = k_q;
      pend_d  = pend_q;
      pk_d    = pk_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      vis_d   = vis_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      fcnt_d  = fcnt_q;
      hit_d   = hit_q;
      rev_d   = rev_q;
      addr_d  = addr_q;
      wen_d   = 1'b0;
      wdata_d = wdata_q;
      push    = 1'b0;
      push_id = cur_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cur_d  = start_id;
               hit_d  = 1'b0;
               rev_d  = '0;
               vis_d  = '0;
               wr_d   = '0;
               rd_d   = '0;
               fcnt_d = '0;
               if (start_ok) addr_d = cell_addr(start_id);
            end
         end
         S_CHECK: begin
            if (rd_mine) begin
               hit_d = 1'b1;
            end else if (rd_safe) begin
               vis_d[cur_q] = 1'b1;
               push         = 1'b1;
            end
         end
         S_POP: begin
            if (fcnt_q != '0) begin
               cur_d  = fifo_q[rd_q];
               rd_d   = inc(rd_q);
               fcnt_d = fcnt_q - 1'b1;
               k_d    = 4'd0;
               pend_d = 1'b0;
               cnt_d  = 4'd0;
               mask_d = 8'd0;
            end
         end
         S_SCAN: begin
            // Data for the read issued last cycle arrives now.
            if (pend_q) begin
               if (rd_mine) cnt_d = cnt_q + 1'b1;
               if (rd_safe && !vis_q[nb_p]) mask_d[pk_q] = 1'b1;
            end
            if (k_q != 4'd8) begin
               pend_d = nb_k_ok;
               pk_d   = k_q[2:0];
               k_d    = k_q + 1'b1;
               if (nb_k_ok) addr_d = cell_addr(nb_k);
            end else begin
               pend_d  = 1'b0;
               wen_d   = 1'b1;
               addr_d  = cell_addr(cur_q);
               wdata_d = DATA_WIDTH'(cnt_d);
            end
         end
         S_WRITE: rev_d = rev_q + 1'b1;
         S_PUSH: begin
            if (mask_q != 8'd0) begin
               push        = 1'b1;
               push_id     = nb_l;
               vis_d[nb_l] = 1'b1;
               mask_d      = mask_nxt;
            end
         end
         default: ;
      endcase
      if (push) begin
         wr_d   = inc(wr_q);
         fcnt_d = fcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : dp_reg
      if (!rst_n) begin
         cur_q   <= '0;
         k_q     <= '0;
         pend_q  <= 1'b0;
         pk_q    <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
         vis_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         fcnt_q  <= '0;
         hit_q   <= 1'b0;
         rev_q   <= '0;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
      end else begin
         cur_q   <= cur_d;
         k_q     <= k_d;
         pend_q  <= pend_d;
         pk_q    <= pk_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         vis_q   <= vis_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         fcnt_q  <= fcnt_d;
         hit_q   <= hit_d;
         rev_q   <= rev_d;
         addr_q  <= addr_d;
         wen_q   <= wen_d;
         wdata_q <= wdata_d;
      end
   end

   always_ff @(posedge clk) begin : fifo_mem
      if (push) fifo_q[wr_q] <= push_id;
   end

   assign mem_addr       = addr_q;
   assign mem_wEn        = wen_q;
   assign mem_wdata      = wdata_q;
   assign hit_mine       = hit_q;
   assign revealed_count = rev_q;

endmodule

// File: tb/tb_reveal_flood_controller.sv
// tb_reveal_flood_controller: directed reveals against a BFS board model.
// A negedge monitor checks every RAM write and every done pulse.
module tb_reveal_flood_controller;
   localparam int N = 25;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [4:0]  start_id;
   logic [9:0]  mem_addr;
   logic        mem_wEn;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy, done, hit_mine;
   logic [4:0]  revealed_count;

   logic [31:0] ram   [N];
   logic [31:0] exp_b [N];
   bit          exp_wr [N];
   int          exp_rev;
   bit          exp_hit;
   int          n_chk = 0;
   int          n_err = 0;
   int          wr_cnt = 0;
   int          done_cnt = 0;
   int          nines;

   reveal_flood_controller dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .start_id       (start_id),
      .mem_addr       (mem_addr),
      .mem_wEn        (mem_wEn),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .busy           (busy),
      .done           (done),
      .hit_mine       (hit_mine),
      .revealed_count (revealed_count)
   );

   always #5 clk = ~clk;

   assign mem_rdata = (mem_addr < 10'd25) ? ram[mem_addr[4:0]]
                                          : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (mem_wEn && mem_addr < 10'd25) ram[mem_addr[4:0]] <= mem_wdata;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic fill(input logic [31:0] v);
      for (int i = 0; i < N; i++) ram[i] = v;
   endtask

   // Plain breadth-first reveal over a snapshot of the board.
   task automatic compute_model(input int s);
      int q[$];
      bit vis [N];
      int cur, r, c, cnt, nr, nc, n;
      for (int i = 0; i < N; i++) begin
         exp_b[i]  = ram[i];
         exp_wr[i] = 1'b0;
         vis[i]    = 1'b0;
      end
      exp_hit = 1'b0;
      exp_rev = 0;
      if (s >= N) return;
      if (exp_b[s] == 32'd10) begin
         exp_hit = 1'b1;
         return;
      end
      if (exp_b[s] != 32'd9) return;
      vis[s] = 1'b1;
      q.push_back(s);
      while (q.size() > 0) begin
         cur = q.pop_front();
         r = cur / 5;
         c = cur % 5;
         cnt = 0;
         for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) begin
               nr = r + dr;
               nc = c + dc;
               if ((dr != 0 || dc != 0) && nr >= 0 && nr < 5 &&
                   nc >= 0 && nc < 5 && exp_b[nr*5+nc] == 32'd10)
                  cnt++;
            end
         exp_b[cur]  = 32'(cnt);
         exp_wr[cur] = 1'b1;
         exp_rev++;
         if (cnt == 0) begin
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++) begin
                  nr = r + dr;
                  nc = c + dc;
                  if ((dr != 0 || dc != 0) && nr >= 0 && nr < 5 &&
                      nc >= 0 && nc < 5) begin
                     n = nr * 5 + nc;
                     if (exp_b[n] == 32'd9 && !vis[n]) begin
                        vis[n] = 1'b1;
                        q.push_back(n);
                     end
                  end
               end
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (mem_wEn) begin
            wr_cnt++;
            if (mem_addr >= 10'd25) begin
               chk("wr_addr_range", mem_addr, 0);
            end else begin
               chk("wr_expected_cell", exp_wr[mem_addr[4:0]], 1);
               chk("wr_data", mem_wdata, exp_b[mem_addr[4:0]]);
            end
         end
         if (done) begin
            done_cnt++;
            chk("done_hit_mine", hit_mine, exp_hit);
            chk("done_revealed", revealed_count, exp_rev);
            chk("done_busy_low", busy, 0);
         end
      end
   end

   task automatic run_req(input string nm, input int s, input int poke,
                          input int max_lat);
      int w0, d0, n, bad;
      compute_model(s);
      w0 = wr_cnt;
      d0 = done_cnt;
      start_id = 5'(s);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n = 1;
      while (done !== 1'b1 && n < 3000) begin
         start = (poke != 0 && n == poke);
         start_id = 5'd0;
         @(posedge clk);
         #1;
         n++;
      end
      start = 1'b0;
      chk({nm, "_latency"}, (n <= max_lat), 1);
      repeat (4) @(posedge clk);
      #1;
      chk({nm, "_done_once"}, done_cnt - d0, 1);
      chk({nm, "_writes"}, wr_cnt - w0, exp_rev);
      chk({nm, "_rev_hold"}, revealed_count, exp_rev);
      chk({nm, "_hit_hold"}, hit_mine, exp_hit);
      bad = 0;
      for (int i = 0; i < N; i++) if (ram[i] !== exp_b[i]) bad++;
      chk({nm, "_board"}, bad, 0);
   endtask

   task automatic reset_mid(input int s, input int after);
      compute_model(s);
      start_id = 5'(s);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (after) @(posedge clk);
      #2;
      chk("rst_was_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_outputs",
          {busy, done, mem_wEn, hit_mine, mem_addr, mem_wdata,
           revealed_count}, 0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      start_id = 5'd0;
      fill(32'd9);
      #1;
      chk("reset_outputs",
          {busy, done, mem_wEn, hit_mine, mem_addr, mem_wdata,
           revealed_count}, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_not_busy", busy, 0);

      fill(32'd9);
      run_req("all_safe", 12, 20, 3000);
      chk("all_safe_rev_lit", revealed_count, 25);
      chk("all_safe_c0_lit", ram[0], 0);

      fill(32'd9);
      ram[0] = 32'd10;
      run_req("mine_c0", 24, 0, 3000);
      chk("mine_c0_c1_lit", ram[1], 1);
      chk("mine_c0_c5_lit", ram[5], 1);
      chk("mine_c0_c6_lit", ram[6], 1);
      chk("mine_c0_c7_lit", ram[7], 0);
      chk("mine_c0_c0_lit", ram[0], 10);
      chk("mine_c0_rev_lit", revealed_count, 24);

      fill(32'd9);
      ram[7] = 32'd10;
      run_req("hit", 7, 0, 4);
      chk("hit_lit", hit_mine, 1);
      chk("hit_rev_lit", revealed_count, 0);

      fill(32'd9);
      ram[3] = 32'd10;
      ram[8] = 32'd10;
      run_req("corner2", 4, 0, 14);
      chk("corner2_c4_lit", ram[4], 2);
      chk("corner2_rev_lit", revealed_count, 1);
      chk("corner2_c5_lit", ram[5], 9);
      chk("corner2_hit_clr", hit_mine, 0);

      run_req("revealed", 4, 0, 4);
      run_req("out_range", 27, 0, 2);

      fill(32'd9);
      ram[5]  = 32'd10;
      ram[18] = 32'd10;
      ram[21] = 32'd10;
      run_req("mixed", 4, 0, 3000);
      chk("mixed_c4_lit", ram[4], 0);

      fill(32'd9);
      reset_mid(12, 5);
      nines = 0;
      for (int i = 0; i < N; i++) if (ram[i] == 32'd9) nines++;
      run_req("early_rst", 12, 0, 3000);
      chk("early_rst_nines", revealed_count, nines);

      fill(32'd9);
      reset_mid(12, 60);
      run_req("late_rst_c12", 12, 0, 3000);
      run_req("late_rst_c24", 24, 0, 3000);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
